// File: rtl/event_req_pkg.sv
// Shared types and defaults for the event requester.
package event_req_pkg;

  // Requester FSM states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    FIRE = 3'd2,
    WAIT = 3'd3,
    GAP  = 3'd4,
    DONE = 3'd5
  } state_e;

  localparam int DEFAULT_CNT_W   = 16;
  localparam int DEFAULT_GAP_W   = 8;
  localparam int DEFAULT_TIMEOUT = 4;

  // Bits needed to hold a wait counter that runs 1..timeout.
  function automatic int wait_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/event_sat_cnt.sv
// Saturating up-counter with synchronous clear; used for the result tallies.
module event_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Clear wins over increment; an all-ones count holds instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/event_requester.sv
// Initiator for the enable/data_signal -> event_occurred handshake.
// Issues a programmed number of arm/fire requests, times each response and
// keeps pass, timeout and spurious-event tallies.
module event_requester
  import event_req_pkg::*;
#(
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int GAP_W   = DEFAULT_GAP_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_events,
  input  logic [GAP_W-1:0] gap,
  input  logic             event_occurred,
  output logic             enable,
  output logic             data_signal,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [CNT_W-1:0] spurious_cnt
);

  localparam int WAIT_W = wait_cnt_width(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

  state_e           state_d,    state_q;
  logic [CNT_W-1:0] req_left_d, req_left_q;
  logic [GAP_W-1:0] gap_lat_d,  gap_lat_q;
  logic [GAP_W-1:0] gap_cnt_d,  gap_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d, wait_cnt_q;

  logic start_ok;
  logic pass_hit;
  logic timeout_hit;
  logic spurious_hit;
  logic req_finished;

  // Per-cycle events derived from the current state and the monitor response.
  always_comb begin
    start_ok     = (state_q == IDLE) && start;
    pass_hit     = (state_q == WAIT) && event_occurred;
    timeout_hit  = (state_q == WAIT) && !event_occurred && (wait_cnt_q == WAIT_LIMIT);
    spurious_hit = event_occurred &&
                   ((state_q == ARM) || (state_q == FIRE) || (state_q == GAP));
    req_finished = pass_hit || timeout_hit;
  end

  // Next-state logic for the FSM and its request, wait and gap counters.
  always_comb begin
    state_d    = state_q;
    req_left_d = req_left_q;
    gap_lat_d  = gap_lat_q;
    gap_cnt_d  = gap_cnt_q;
    wait_cnt_d = wait_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          req_left_d = num_events;
          gap_lat_d  = gap;
          state_d    = (num_events == '0) ? DONE : ARM;
        end
      end

      ARM: begin
        state_d = FIRE;
      end

      FIRE: begin
        state_d    = WAIT;
        wait_cnt_d = WAIT_W'(1);
      end

      WAIT: begin
        if (req_finished) begin
          if (req_left_q != '0) begin
            req_left_d = req_left_q - CNT_W'(1);
          end
          if (req_left_q <= CNT_W'(1)) begin
            state_d = DONE;
          end else if (gap_lat_q == '0) begin
            state_d = ARM;
          end else begin
            state_d   = GAP;
            gap_cnt_d = gap_lat_q;
          end
        end else if (wait_cnt_q != WAIT_LIMIT) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d = ARM;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and counter registers; reset aborts any run straight back to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      req_left_q <= '0;
      gap_lat_q  <= '0;
      gap_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      req_left_q <= req_left_d;
      gap_lat_q  <= gap_lat_d;
      gap_cnt_q  <= gap_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Handshake and status outputs are pure decodes of the state register.
  always_comb begin
    enable      = (state_q == ARM) || (state_q == FIRE);
    data_signal = (state_q == FIRE);
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
  end

  event_sat_cnt #(.W(CNT_W)) u_pass_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (pass_hit),
    .clr     (start_ok),
    .count   (pass_cnt)
  );

  event_sat_cnt #(.W(CNT_W)) u_timeout_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (timeout_hit),
    .clr     (start_ok),
    .count   (timeout_cnt)
  );

  event_sat_cnt #(.W(CNT_W)) u_spurious_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (spurious_hit),
    .clr     (start_ok),
    .count   (spurious_cnt)
  );

endmodule

// File: tb/tb_event_requester.sv
// Directed bench for event_requester: a default-width instance plus a
// 2-bit-tally, TIMEOUT=1 instance for saturation checks.
module tb_event_requester;

  logic        clk;
  logic        reset_n;

  logic        start;
  logic [15:0] num_events;
  logic [7:0]  gap;
  logic        event_occurred;
  logic        enable, data_signal, busy, done;
  logic [15:0] pass_cnt, timeout_cnt, spurious_cnt;

  logic        auto_mon;
  logic        mon_ev;
  logic        ev_drive;

  logic        s_start;
  logic [1:0]  s_num;
  logic [7:0]  s_gap;
  logic        s_ev;
  logic        s_enable, s_data_signal, s_busy, s_done;
  logic [1:0]  s_pass, s_timeout, s_spur;

  int n_checks;
  int n_fail;
  int cyc;
  int en_cyc;

  event_requester #(.CNT_W(16), .GAP_W(8), .TIMEOUT(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .num_events     (num_events),
    .gap            (gap),
    .event_occurred (event_occurred),
    .enable         (enable),
    .data_signal    (data_signal),
    .busy           (busy),
    .done           (done),
    .pass_cnt       (pass_cnt),
    .timeout_cnt    (timeout_cnt),
    .spurious_cnt   (spurious_cnt)
  );

  event_requester #(.CNT_W(2), .GAP_W(8), .TIMEOUT(1)) dut_small (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (s_start),
    .num_events     (s_num),
    .gap            (s_gap),
    .event_occurred (s_ev),
    .enable         (s_enable),
    .data_signal    (s_data_signal),
    .busy           (s_busy),
    .done           (s_done),
    .pass_cnt       (s_pass),
    .timeout_cnt    (s_timeout),
    .spurious_cnt   (s_spur)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Well-behaved monitor: answers the cycle after it sees data_signal high.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) mon_ev <= 1'b0;
    else          mon_ev <= auto_mon && data_signal;
  end

  assign event_occurred = mon_ev | ev_drive;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge: pulse start for one cycle, return at negedge of cycle 1.
  task automatic applyStimulus(input bit sel_small, input logic [15:0] n, input logic [7:0] g);
    if (sel_small) begin
      s_num   = n[1:0];
      s_gap   = g;
      s_start = 1'b1;
    end else begin
      num_events = n;
      gap        = g;
      start      = 1'b1;
    end
    @(negedge clk);
    start   = 1'b0;
    s_start = 1'b0;
  endtask

  // Walk cycles from cycle 1 until done is seen; done_cyc stays 0 if budget expires.
  task automatic runUntilDone(input bit sel_small, input int budget,
                              output int done_cyc, output int en_cnt);
    done_cyc = 0;
    en_cnt   = 0;
    for (int i = 1; i <= budget; i++) begin
      if (sel_small ? s_enable : enable) en_cnt++;
      if (sel_small ? s_done : done) begin
        done_cyc = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Hard stop in case the sequence itself stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    start      = 1'b0;
    num_events = '0;
    gap        = '0;
    auto_mon   = 1'b0;
    ev_drive   = 1'b0;
    s_start    = 1'b0;
    s_num      = '0;
    s_gap      = '0;
    s_ev       = 1'b0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_enable",   enable,       0);
    checkOutput("rst_data",     data_signal,  0);
    checkOutput("rst_busy",     busy,         0);
    checkOutput("rst_done",     done,         0);
    checkOutput("rst_pass",     pass_cnt,     0);
    checkOutput("rst_timeout",  timeout_cnt,  0);
    checkOutput("rst_spurious", spurious_cnt, 0);
    checkOutput("rst_s_busy",   s_busy,       0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] test 1: three answered requests, gap 2");
    auto_mon = 1'b1;
    applyStimulus(1'b0, 16'd3, 8'd2);
    runUntilDone(1'b0, 40, cyc, en_cyc);
    checkOutput("t1_done_cycle", cyc,          14);
    checkOutput("t1_en_cycles",  en_cyc,       6);
    checkOutput("t1_pass",       pass_cnt,     3);
    checkOutput("t1_timeout",    timeout_cnt,  0);
    checkOutput("t1_spurious",   spurious_cnt, 0);
    @(negedge clk);
    checkOutput("t1_done_low",   done,         0);
    checkOutput("t1_busy_low",   busy,         0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t1_pass_hold",  pass_cnt,     3);

    $display("[TB] test 2: no response, two timeouts");
    auto_mon = 1'b0;
    applyStimulus(1'b0, 16'd2, 8'd0);
    runUntilDone(1'b0, 40, cyc, en_cyc);
    checkOutput("t2_done_cycle", cyc,         13);
    checkOutput("t2_en_cycles",  en_cyc,      4);
    checkOutput("t2_timeout",    timeout_cnt, 2);
    checkOutput("t2_pass",       pass_cnt,    0);
    @(negedge clk);
    checkOutput("t2_done_once",  done,        0);

    $display("[TB] test 3: zero requests");
    applyStimulus(1'b0, 16'd0, 8'd5);
    checkOutput("t3_busy_c1",    busy, 1);
    runUntilDone(1'b0, 10, cyc, en_cyc);
    checkOutput("t3_done_cycle", cyc,    1);
    checkOutput("t3_en_cycles",  en_cyc, 0);
    @(negedge clk);
    checkOutput("t3_busy_c2",    busy,        0);
    checkOutput("t3_timeout",    timeout_cnt, 0);

    $display("[TB] test 4: spurious events, ignored starts");
    auto_mon = 1'b1;
    applyStimulus(1'b0, 16'd2, 8'd3);
    cyc = 0;
    for (int i = 1; i <= 12; i++) begin
      ev_drive = (i == 5) || (i == 7) || (i == 11);
      start    = (i == 4) || (i == 10);
      if (i == 4) num_events = 16'd9;
      if (done && cyc == 0) cyc = i;
      if (i == 11) checkOutput("t4_idle_after_done", busy, 0);
      @(negedge clk);
    end
    ev_drive = 1'b0;
    start    = 1'b0;
    checkOutput("t4_done_cycle", cyc,          10);
    checkOutput("t4_spurious",   spurious_cnt, 2);
    checkOutput("t4_pass",       pass_cnt,     2);
    checkOutput("t4_timeout",    timeout_cnt,  0);

    $display("[TB] test 5: reset during WAIT");
    auto_mon = 1'b0;
    applyStimulus(1'b0, 16'd1, 8'd0);
    ev_drive = 1'b1;
    checkOutput("t5_arm_enable", enable,      1);
    checkOutput("t5_arm_data",   data_signal, 0);
    @(negedge clk);
    ev_drive = 1'b0;
    checkOutput("t5_fire_enable", enable,      1);
    checkOutput("t5_fire_data",   data_signal, 1);
    @(negedge clk);
    checkOutput("t5_wait_enable", enable,       0);
    checkOutput("t5_wait_busy",   busy,         1);
    checkOutput("t5_spur_before", spurious_cnt, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("t5_rst_busy",     busy,         0);
    checkOutput("t5_rst_enable",   enable,       0);
    checkOutput("t5_rst_done",     done,         0);
    checkOutput("t5_rst_spurious", spurious_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    auto_mon = 1'b1;
    applyStimulus(1'b0, 16'd1, 8'd0);
    runUntilDone(1'b0, 20, cyc, en_cyc);
    checkOutput("t5_done_cycle", cyc,          4);
    checkOutput("t5_pass",       pass_cnt,     1);
    checkOutput("t5_spurious",   spurious_cnt, 0);
    @(negedge clk);
    auto_mon = 1'b0;

    $display("[TB] test 6: 2-bit tallies saturate");
    s_ev = 1'b0;
    applyStimulus(1'b1, 16'd3, 8'd0);
    runUntilDone(1'b1, 40, cyc, en_cyc);
    checkOutput("t6_done_cycle_a", cyc,       10);
    checkOutput("t6_timeout_a",    s_timeout, 3);
    checkOutput("t6_pass_a",       s_pass,    0);
    @(negedge clk);
    s_ev = 1'b1;
    applyStimulus(1'b1, 16'd3, 8'd5);
    runUntilDone(1'b1, 60, cyc, en_cyc);
    checkOutput("t6_done_cycle_b", cyc,       20);
    checkOutput("t6_pass_b",       s_pass,    3);
    checkOutput("t6_spurious_b",   s_spur,    3);
    checkOutput("t6_timeout_b",    s_timeout, 0);
    @(negedge clk);
    s_ev = 1'b0;
    @(negedge clk);
    checkOutput("t6_spurious_hold", s_spur, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
